// File: rtl/zpu_boot_pkg.sv
// rtl/zpu_boot_pkg.sv - shared types and constants for the ZPU boot image loader
package zpu_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_ADDR,
        S_FETCH,
        S_WRITE,
        S_DONE,
        S_ERROR
    } boot_state_t;

    // Byte offsets of the loader's registers on its settings bus
    localparam logic [3:0] LDR_REG_ADDR = 4'h0;
    localparam logic [3:0] LDR_REG_DATA = 4'h4;

    // Width of the running image checksum
    localparam int CKSUM_WIDTH = 32;

endpackage

// File: rtl/zpu_boot_loader_ctrl.sv
// rtl/zpu_boot_loader_ctrl.sv - streams a firmware image into the ZPU bootram loader (optional checksum: ZPU_BOOT_CKSUM_EN)
module zpu_boot_loader_ctrl
    import zpu_boot_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 16,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [15:0] MAX_ADDR    = 16'h7FFC,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic                  ldr_stb,
    output logic                  ldr_wea,
    output logic [ADDR_WIDTH-1:0] ldr_addra,
    output logic [DATA_WIDTH-1:0] ldr_dina,
    input  logic                  ldr_acka,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [12:0]           words_written
);

    // Index of the final image word; the image is LAST_IDX+1 words long
    localparam logic [12:0] LAST_IDX  = 13'(MAX_ADDR >> 2);
    localparam logic [8:0]  TMO_LIMIT = 9'(ACK_TIMEOUT - 1);

    boot_state_t           state_q;
    boot_state_t           state_d;
    logic [12:0]           ww_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [8:0]            tmo_q;
    logic                  bus_active;
    logic                  tmo_hit;
    logic                  is_last;
    logic                  restart;

    // ww_q is the index of the word currently being fetched or written
    assign is_last    = (ww_q == LAST_IDX);
    assign bus_active = (state_q == S_SET_ADDR) || (state_q == S_WRITE);
    // An ack in the final allowed cycle still counts as in time
    assign tmo_hit    = bus_active && (tmo_q == TMO_LIMIT) && !ldr_acka;
    assign restart    = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

`ifdef ZPU_BOOT_CKSUM_EN
    logic [CKSUM_WIDTH-1:0] sum_q;
    logic [CKSUM_WIDTH-1:0] exp_q;
    logic                   ck_pend_q;
    logic                   sum_ok;

    // The final word is folded into the sum combinationally so a bad image never reaches the bootram
    assign sum_ok = ((sum_q + CKSUM_WIDTH'(s_tdata)) == exp_q);

    // Checksum capture and running modulo-2^32 sum of accepted data words
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            exp_q     <= '0;
            ck_pend_q <= 1'b0;
        end else if (restart) begin
            sum_q     <= '0;
            ck_pend_q <= 1'b0;
        end else if (state_q == S_SET_ADDR && ldr_acka) begin
            ck_pend_q <= 1'b1;
        end else if (state_q == S_FETCH && s_tvalid && !abort) begin
            if (ck_pend_q) begin
                exp_q     <= CKSUM_WIDTH'(s_tdata);
                ck_pend_q <= 1'b0;
            end else begin
                sum_q <= sum_q + CKSUM_WIDTH'(s_tdata);
            end
        end
    end
`endif

    // State register, word counter, captured word and ack timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ww_q    <= '0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                ww_q <= '0;
            end else if (state_q == S_WRITE && ldr_acka) begin
                ww_q <= ww_q + 13'd1;
            end
            if (state_q == S_FETCH && s_tvalid) begin
                data_q <= s_tdata;
            end
            if (bus_active && state_d == state_q) begin
                tmo_q <= tmo_q + 9'd1;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // Next-state logic; abort outranks ack and timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SET_ADDR;
            end
            S_SET_ADDR: begin
                if (abort)         state_d = S_ERROR;
                else if (ldr_acka) state_d = S_FETCH;
                else if (tmo_hit)  state_d = S_ERROR;
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else if (s_tvalid) begin
`ifdef ZPU_BOOT_CKSUM_EN
                    if (ck_pend_q)                 state_d = S_FETCH;
                    else if (is_last != s_tlast)   state_d = S_ERROR;
                    else if (is_last && !sum_ok)   state_d = S_ERROR;
                    else                           state_d = S_WRITE;
`else
                    // tlast must land exactly on the final index: early is short, missing is long
                    if (is_last != s_tlast) state_d = S_ERROR;
                    else                    state_d = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                if (abort)         state_d = is_last ? S_ERROR : S_ERROR;
                else if (ldr_acka) state_d = is_last ? S_DONE : S_FETCH;
                else if (tmo_hit)  state_d = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        s_tready  = 1'b0;
        ldr_stb   = 1'b0;
        ldr_wea   = 1'b0;
        ldr_addra = '0;
        ldr_dina  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            S_SET_ADDR: begin
                ldr_stb   = 1'b1;
                ldr_wea   = 1'b1;
                ldr_addra = ADDR_WIDTH'(LDR_REG_ADDR);
                busy      = 1'b1;
            end
            S_FETCH: begin
                s_tready = 1'b1;
                busy     = 1'b1;
            end
            S_WRITE: begin
                ldr_stb   = 1'b1;
                ldr_wea   = 1'b1;
                ldr_addra = ADDR_WIDTH'(LDR_REG_DATA);
                ldr_dina  = data_q;
                busy      = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign words_written = ww_q;

endmodule
